// File: rtl/img_stream_filter.sv
// 3x3 raster-stream filter: two line buffers feed a sliding window, a two-stage
// kernel pipeline (pass / 1-2-1 Gaussian / Laplacian) and an FWFT output FIFO.
module img_stream_filter #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  input  logic [1:0]        i_mode,
  output logic              o_intr
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = DATA_W + 4;
  localparam int LW = DATA_W + 5;
  localparam logic [LW-1:0] MAXV = LW'((1 << DATA_W) - 1);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [1:0]        r_mode;
  logic              r_rdy;
  logic              r_intr;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] w_col_in [3];
  logic [DATA_W-1:0] w_win [3][3];
  logic              w_accept, w_produce, w_last;

  assign w_accept  = i_data_valid & r_rdy;
  assign w_produce = w_accept & (r_row >= RW'(2)) & (r_col >= CW'(2));
  assign w_last    = (r_row == RW'(IMG_H - 1)) & (r_col == CW'(IMG_W - 1));

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= 2'd0;
    end else if (w_accept) begin
      // Kernel choice is frozen for the whole frame on its first pixel.
      if (r_col == '0 && r_row == '0)
        r_mode <= (i_mode == 2'd3) ? 2'd0 : i_mode;
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= i_data;
      r_lb1[r_col] <= r_lb0[r_col];
    end
  end

  assign w_col_in[0] = r_lb1[r_col];
  assign w_col_in[1] = r_lb0[r_col];
  assign w_col_in[2] = i_data;

  // Row gi of the window: tap 0 is the oldest column, tap 2 the newest.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] r_tap [3];
      always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
          r_tap[0] <= '0;
          r_tap[1] <= '0;
          r_tap[2] <= '0;
        end else if (w_accept) begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= w_col_in[gi];
        end
      end
      assign w_win[gi][0] = r_tap[0];
      assign w_win[gi][1] = r_tap[1];
      assign w_win[gi][2] = r_tap[2];
    end
  endgenerate

  logic [GW-1:0]        w_gauss;
  logic [LW-1:0]        w_nsum;
  logic signed [LW-1:0] w_lap;

  assign w_gauss = GW'(w_win[0][0]) + (GW'(w_win[0][1]) << 1) + GW'(w_win[0][2])
                 + (GW'(w_win[1][0]) << 1) + (GW'(w_win[1][1]) << 2) + (GW'(w_win[1][2]) << 1)
                 + GW'(w_win[2][0]) + (GW'(w_win[2][1]) << 1) + GW'(w_win[2][2]);
  assign w_nsum  = LW'(w_win[0][0]) + LW'(w_win[0][1]) + LW'(w_win[0][2])
                 + LW'(w_win[1][0]) + LW'(w_win[1][2])
                 + LW'(w_win[2][0]) + LW'(w_win[2][1]) + LW'(w_win[2][2]);
  assign w_lap   = signed'((LW'(w_win[1][1]) << 3) - w_nsum);

  logic                 r_s0_valid, r_s0_last;
  logic                 r_s1_valid, r_s1_last;
  logic [1:0]           r_s1_mode;
  logic [DATA_W-1:0]    r_s1_centre;
  logic [GW-1:0]        r_s1_gauss;
  logic signed [LW-1:0] r_s1_lap;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s0_valid <= w_produce;
      r_s0_last  <= w_produce & w_last;
      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
    end
    r_s1_mode   <= r_mode;
    r_s1_centre <= w_win[1][1];
    r_s1_gauss  <= w_gauss;
    r_s1_lap    <= w_lap;
  end

  logic [LW-1:0]     w_abs;
  logic [DATA_W-1:0] w_result;

  assign w_abs = r_s1_lap[LW-1] ? LW'(-r_s1_lap) : LW'(r_s1_lap);

  always_comb begin
    w_result = r_s1_centre;
    case (r_s1_mode)
      2'd1:    w_result = DATA_W'(r_s1_gauss >> 4);
      2'd2:    w_result = (w_abs > MAXV) ? DATA_W'(MAXV) : DATA_W'(w_abs);
      default: w_result = r_s1_centre;
    endcase
  end

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              w_push, w_pop, w_nempty;

  assign w_nempty = (r_count != '0);
  assign w_push   = r_s1_valid;
  assign w_pop    = w_nempty & i_data_ready;

  always_ff @(posedge axi_clk) begin
    if (w_push) r_fifo[r_wptr] <= w_result;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdy   <= 1'b0;
      r_intr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Slack of 4 absorbs this register's lag, two pipeline stages and the current push.
      r_rdy  <= (r_count < (AW+1)'(FIFO_DEPTH - 4));
      r_intr <= r_s1_valid & r_s1_last;
    end
  end

  assign o_data_ready = r_rdy;
  assign o_data_valid = w_nempty;
  assign o_data       = w_nempty ? r_fifo[r_rptr] : '0;
  assign o_intr       = r_intr;

endmodule

// File: tb/tb_img_stream_filter.sv
// Self-checking bench for img_stream_filter: frame table plus hand sequences,
// checked against an image-level kernel model and an occupancy model.
module tb_img_stream_filter;
  localparam int DW = 8, W = 8, H = 6, FD = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          axi_clk = 1'b0, axi_reset = 1'b1;
  logic          i_data_valid = 1'b0, i_data_ready = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic [1:0]    i_mode = 2'd0;
  logic          o_data_ready, o_data_valid, o_intr;
  logic [DW-1:0] o_data;

  always #5 axi_clk = ~axi_clk;

  img_stream_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(FD)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
    .i_mode(i_mode), .o_intr(o_intr)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  int img [H][W];

  // Monitor state (written only by the monitor; initial block requests clears via clr_seq).
  int got[$];
  int pend[$];
  int intr_cnt = 0, intr_data = -1, intr_pos = -1;
  int acc_idx = 0, written = 0, popped = 0, vmis = 0, max_occ = 0;
  int first_valid = -1, acc22_edge = -1, saw_rdy_low = 0;
  int clr_seq = 0, clr_seen = 0;
  int occ, pr, pc;

  always @(negedge axi_clk) begin
    if (axi_reset) begin
      acc_idx = 0; written = 0; popped = 0;
      pend.delete(); got.delete(); intr_cnt = 0;
    end else begin
      if (clr_seq != clr_seen) begin
        clr_seen = clr_seq; got.delete(); intr_cnt = 0; intr_data = -1; intr_pos = -1;
        vmis = 0; max_occ = 0; first_valid = -1; acc22_edge = -1; saw_rdy_low = 0;
      end
      while (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        written++;
      end
      occ = written - popped;
      if (occ > max_occ) max_occ = occ;
      if (o_data_valid !== (occ > 0)) vmis++;
      if (!o_data_ready) saw_rdy_low = 1;
      if (o_data_valid && first_valid < 0) first_valid = cyc;
      if (o_intr) begin intr_cnt++; intr_data = int'(o_data); intr_pos = got.size(); end
      if (i_data_valid && o_data_ready) begin
        pr = acc_idx / W; pc = acc_idx % W;
        if (pr >= 2 && pc >= 2) pend.push_back(cyc + 3);
        if (acc_idx == 2 * W + 2) acc22_edge = cyc + 1;
        acc_idx = (acc_idx + 1) % (W * H);
      end
      if (o_data_valid && i_data_ready) begin got.push_back(int'(o_data)); popped++; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk); #1;
  endtask

  function automatic int got_at(input int j);
    return (j < got.size()) ? got[j] : -1;
  endfunction

  // Kernel applied to the stored image around centre (r,c).
  function automatic int exp_px(input int mode, input int r, input int c);
    int s, n, v;
    s = 0; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        s += img[r+dr][c+dc] * (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
        if (dr != 0 || dc != 0) n += img[r+dr][c+dc];
      end
    case (mode)
      1: return s / 16;
      2: begin v = 8 * img[r][c] - n; if (v < 0) v = -v; return (v > 255) ? 255 : v; end
      default: return img[r][c];
    endcase
  endfunction

  task automatic fill_img(input int pat, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = r * W + c;
          1: img[r][c] = val;
          2: img[r][c] = (r == 2 && c == 3) ? val : 0;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic run_frame(input string tag, input int mode, input int vp, input int rp,
                           input int hold, input int sw_at, input int sw_mode);
    int k, n, acc;
    clr_seq++;
    tick();
    i_mode = 2'(mode);
    k = 0; n = 0;
    while (k < W * H && n < 5000) begin
      i_data_ready = (n < hold) ? 1'b0 : (int'($urandom_range(99)) < rp);
      if (sw_at >= 0 && k >= sw_at) i_mode = 2'(sw_mode);
      i_data_valid = (int'($urandom_range(99)) < vp);
      i_data = DW'(img[k / W][k % W]);
      @(negedge axi_clk);
      acc = int'(i_data_valid && o_data_ready);
      @(posedge axi_clk); #1;
      k += acc; n++;
    end
    i_data_valid = 1'b0; i_data_ready = 1'b1;
    check({tag, " fed"}, k, W * H);
    n = 0;
    while ((got.size() < NOUT || pend.size() > 0) && n < 300) begin tick(); n++; end
    repeat (5) tick();
    check({tag, " count"}, got.size(), NOUT);
    for (int j = 0; j < NOUT; j++)
      check($sformatf("%s out%0d", tag, j), got_at(j), exp_px(mode, 1 + j / (W - 2), 1 + j % (W - 2)));
    check({tag, " intr_cnt"}, intr_cnt, 1);
    check({tag, " valid_vs_occ"}, vmis, 0);
    check({tag, " occ_le_depth"}, int'(max_occ <= FD), 1);
    check({tag, " latency"}, first_valid - acc22_edge, 2);
    if (rp == 100 && hold == 0) begin
      check({tag, " intr_data"}, intr_data, exp_px(mode, H - 2, W - 2));
      check({tag, " intr_pos"}, intr_pos, NOUT - 1);
    end
  endtask

  typedef struct {
    int mode; int pat; int val; int vp; int rp; int exp_first; int exp_last;
  } frame_t;
  typedef struct {
    int mode; int r; int c; int exp;
  } spot_t;

  frame_t tv[9];
  spot_t  sp[18];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    tv[0] = '{0, 0, 0, 100, 100, 9, 38};
    tv[1] = '{1, 1, 100, 100, 100, 100, 100};
    tv[2] = '{1, 2, 16, 100, 100, 0, 0};
    tv[3] = '{2, 1, 77, 100, 100, 0, 0};
    tv[4] = '{2, 2, 255, 100, 100, 0, 0};
    tv[5] = '{3, 0, 0, 100, 100, 9, 38};
    tv[6] = '{0, 0, 0, 60, 60, 9, 38};
    tv[7] = '{2, 3, 0, 70, 80, -1, -1};
    tv[8] = '{1, 3, 0, 80, 50, -1, -1};
    sp[0]  = '{1, 2, 3, 4};   sp[1]  = '{1, 1, 3, 2};   sp[2]  = '{1, 3, 3, 2};
    sp[3]  = '{1, 2, 2, 2};   sp[4]  = '{1, 2, 4, 2};   sp[5]  = '{1, 1, 2, 1};
    sp[6]  = '{1, 1, 4, 1};   sp[7]  = '{1, 3, 2, 1};   sp[8]  = '{1, 3, 4, 1};
    sp[9]  = '{1, 4, 6, 0};   sp[10] = '{1, 1, 1, 0};
    sp[11] = '{2, 2, 3, 255}; sp[12] = '{2, 1, 2, 255}; sp[13] = '{2, 3, 4, 255};
    sp[14] = '{2, 2, 4, 255}; sp[15] = '{2, 4, 3, 0};   sp[16] = '{2, 2, 5, 0};
    sp[17] = '{2, 1, 1, 0};

    // Reset: three edges with reset high, outputs held at 0.
    tick();
    repeat (2) begin
      @(negedge axi_clk);
      check("rst o_data_ready", int'(o_data_ready), 0);
      check("rst o_data_valid", int'(o_data_valid), 0);
      check("rst o_data", int'(o_data), 0);
      check("rst o_intr", int'(o_intr), 0);
      @(posedge axi_clk); #1;
    end
    axi_reset = 1'b0;
    @(negedge axi_clk);
    check("rel1 o_data_ready", int'(o_data_ready), 0);
    @(posedge axi_clk); #1;
    @(negedge axi_clk);
    check("rel2 o_data_ready", int'(o_data_ready), 1);
    n = 0;
    repeat (6) begin @(negedge axi_clk); n += int'(o_data_valid); end
    check("idle o_data_valid", n, 0);
    tick();

    for (int i = 0; i < 9; i++) begin
      fill_img(tv[i].pat, tv[i].val);
      run_frame($sformatf("frame%0d", i), tv[i].mode, tv[i].vp, tv[i].rp, 0, -1, 0);
      if (tv[i].exp_first >= 0) begin
        check($sformatf("frame%0d first", i), got_at(0), tv[i].exp_first);
        check($sformatf("frame%0d last", i), got_at(NOUT - 1), tv[i].exp_last);
      end
      if (tv[i].pat == 2)
        for (int s = 0; s < 18; s++)
          if (sp[s].mode == tv[i].mode)
            check($sformatf("frame%0d spot(%0d,%0d)", i, sp[s].r, sp[s].c),
                  got_at((sp[s].r - 1) * (W - 2) + sp[s].c - 1), sp[s].exp);
    end

    // Backpressure: downstream stalled while input stays valid.
    fill_img(0, 0);
    run_frame("bp_hold", 0, 100, 100, 60, -1, 0);
    check("bp_hold ready_fell", saw_rdy_low, 1);
    run_frame("bp_rand", 0, 50, 40, 20, -1, 0);

    // Reset mid-frame, then a Gaussian frame with a mid-frame mode change.
    fill_img(0, 0);
    i_mode = 2'd1; k = 0; n = 0;
    while (k < 20 && n < 200) begin
      i_data_valid = 1'b1; i_data = DW'(img[k / W][k % W]);
      @(negedge axi_clk);
      n++;
      if (o_data_ready) k++;
      @(posedge axi_clk); #1;
    end
    check("pre_rst fed", k, 20);
    i_data_valid = 1'b0;
    axi_reset = 1'b1;
    tick(); tick();
    axi_reset = 1'b0;
    fill_img(3, 0);
    run_frame("mid_rst", 1, 100, 100, 0, 30, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
